// File: rtl/weight_bit_serializer_pkg.sv
// Shared types and helpers for the bit-serial weight sequencer.
// Optional feature macro: SERIALIZER_VAR_PREC_EN (per-vector precision).
package weight_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int calc_prec_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  // Out-of-range precisions (0 or wider than the datapath) fall back to full width.
  function automatic int unsigned prec_clamp(input int unsigned prec,
                                             input int unsigned data_width);
    int unsigned p;
    if ((prec == 32'd0) || (prec > data_width)) begin
      p = data_width;
    end else begin
      p = prec;
    end
    return p;
  endfunction

endpackage

// File: rtl/weight_bit_serializer_lane_shift_reg.sv
// One lane of the weight serializer: parallel load with pre-shift, then
// shift left one bit per cycle; the MSB is the current bit-plane.
module weight_bit_serializer_lane_shift_reg #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic [DATA_WIDTH-1:0]  d_in,
  input  logic [SHAMT_WIDTH-1:0] pre_shift,
  output logic                   msb
);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_d;

  // Next lane contents: load has priority; zeros shift in from the LSB.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d_in << pre_shift;
    end else if (shift) begin
      sr_d = {sr_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Lane register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[DATA_WIDTH-1];

endmodule

// File: rtl/weight_bit_serializer.sv
// Bit-serial weight sequencer: MSB-first bit-planes plus MAC strobes.
// Define SERIALIZER_VAR_PREC_EN to add the per-vector w_prec input.
module weight_bit_serializer
  import weight_bit_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  parameter int PREC_WIDTH = calc_prec_width(DATA_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic signed [DATA_WIDTH-1:0] w_in [VEC_LENGTH],
`ifdef SERIALIZER_VAR_PREC_EN
  input  logic [PREC_WIDTH-1:0]        w_prec,
`endif
  output logic [VEC_LENGTH-1:0]        w_bit,
  output logic                         is_msb,
  output logic                         is_msb_delayed,
  output logic                         mac_en,
  output logic                         busy,
  output logic                         result_valid
);

  state_e                state_q, state_d;
  logic [PREC_WIDTH-1:0] cnt_q, cnt_d;
  logic [PREC_WIDTH-1:0] load_prec_s;
  logic [PREC_WIDTH-1:0] pre_shift_s;
  logic                  is_msb_q, is_msb_d;
  logic                  is_msb_dly_q;
  logic                  mac_en_q, mac_en_d;
  logic                  busy_q, busy_d;
  logic                  last_dly_q;
  logic                  result_valid_q;
  logic                  last_bit_s;
  logic                  hs_s;
  logic                  load_s;
  logic                  shift_s;

`ifdef SERIALIZER_VAR_PREC_EN
  assign load_prec_s = PREC_WIDTH'(prec_clamp(32'(w_prec), 32'(DATA_WIDTH)));
`else
  assign load_prec_s = PREC_WIDTH'(DATA_WIDTH);
`endif
  // Left-align a P-bit weight so its sign bit lands in the lane MSB.
  assign pre_shift_s = PREC_WIDTH'(DATA_WIDTH) - load_prec_s;

  assign last_bit_s = (state_q == SHIFT) && (cnt_q == '0);
  assign w_ready    = (state_q == IDLE) || last_bit_s;
  assign hs_s       = w_valid && w_ready;

  // Next-state, counter and strobe logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_msb_d = 1'b0;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          if (hs_s) begin
            load_s = 1'b1;
          end else begin
            shift_s = 1'b1;
            state_d = FLUSH;
          end
        end else begin
          shift_s = 1'b1;
          cnt_d   = cnt_q - PREC_WIDTH'(1);
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_s) begin
      state_d  = SHIFT;
      cnt_d    = load_prec_s - PREC_WIDTH'(1);
      is_msb_d = 1'b1;
    end else begin
      is_msb_d = 1'b0;
    end
    mac_en_d = (state_d != IDLE);
    busy_d   = (state_d != IDLE);
  end

  // State, counter, strobes and the two-stage result pipe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      is_msb_q       <= 1'b0;
      is_msb_dly_q   <= 1'b0;
      mac_en_q       <= 1'b0;
      busy_q         <= 1'b0;
      last_dly_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_msb_q       <= is_msb_d;
      is_msb_dly_q   <= is_msb_q;
      mac_en_q       <= mac_en_d;
      busy_q         <= busy_d;
      last_dly_q     <= last_bit_s;
      result_valid_q <= last_dly_q;
    end
  end

  for (genvar j = 0; j < VEC_LENGTH; j++) begin : g_lane
    logic lane_msb_s;
    weight_bit_serializer_lane_shift_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_WIDTH(PREC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s),
      .shift    (shift_s),
      .d_in     (w_in[j]),
      .pre_shift(pre_shift_s),
      .msb      (lane_msb_s)
    );
    assign w_bit[j] = lane_msb_s;
  end

  assign is_msb         = is_msb_q;
  assign is_msb_delayed = is_msb_dly_q;
  assign mac_en         = mac_en_q;
  assign busy           = busy_q;
  assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Self-checking bench for weight_bit_serializer (SERIALIZER_VAR_PREC_EN aware).
module tb_weight_bit_serializer;

  localparam int DW = 8;
  localparam int VL = 16;
  localparam int PW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 w_valid = 1'b0;
  logic                 w_ready;
  logic signed [DW-1:0] w_in [VL];
`ifdef SERIALIZER_VAR_PREC_EN
  logic [PW-1:0]        w_prec = '0;
`endif
  logic [VL-1:0]        w_bit;
  logic                 is_msb, is_msb_delayed, mac_en, busy, result_valid;

  weight_bit_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk           (clk),
    .reset         (reset),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_in          (w_in),
`ifdef SERIALIZER_VAR_PREC_EN
    .w_prec        (w_prec),
`endif
    .w_bit         (w_bit),
    .is_msb        (is_msb),
    .is_msb_delayed(is_msb_delayed),
    .mac_en        (mac_en),
    .busy          (busy),
    .result_valid  (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] w;
    int         prec;
    int         exp_p;
  } vec_t;

  typedef struct {
    int                  hs;
    int                  p;
    logic [VL-1:0][7:0]  lw;
  } sb_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   drv_p = DW;
  sb_t  sb_q[$];
  int   rv_q[$];
  sb_t  cur;
  sb_t  nrec;
  bit   act = 1'b0;
  bit   flush_now = 1'b0;
  bit   prev_msb = 1'b0;
  bit   nflush;
  bit   hs;
  int   b = 0;
  logic [VL-1:0] exp_bits;
  logic exp_msb, exp_ready, exp_mac, exp_rv;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, a, e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference monitor: expectations follow from accepted vectors only.
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      rv_q.delete();
      act = 1'b0;
      flush_now = 1'b0;
      prev_msb = 1'b0;
    end else begin
      exp_msb = (sb_q.size() > 0) && (sb_q[0].hs + 1 == cyc);
      if (exp_msb) begin
        cur = sb_q.pop_front();
        act = 1'b1;
        b = 0;
        rv_q.push_back(cyc + cur.p + 1);
      end
      exp_bits = '0;
      if (act) begin
        for (int j = 0; j < VL; j++) exp_bits[j] = cur.lw[j][cur.p - 1 - b];
      end
      exp_mac   = act || flush_now;
      exp_ready = act ? (b == cur.p - 1) : !flush_now;
      exp_rv    = (rv_q.size() > 0) && (rv_q[0] == cyc);
      if (exp_rv) void'(rv_q.pop_front());
      chk("w_bit", 64'(w_bit), 64'(exp_bits));
      chk("is_msb", 64'(is_msb), 64'(exp_msb));
      chk("is_msb_delayed", 64'(is_msb_delayed), 64'(prev_msb));
      chk("mac_en", 64'(mac_en), 64'(exp_mac));
      chk("busy", 64'(busy), 64'(exp_mac));
      chk("w_ready", 64'(w_ready), 64'(exp_ready));
      chk("result_valid", 64'(result_valid), 64'(exp_rv));
      hs = w_valid && exp_ready;
      if (hs) begin
        nrec.hs = cyc;
        nrec.p  = drv_p;
        for (int j = 0; j < VL; j++) nrec.lw[j] = w_in[j];
        sb_q.push_back(nrec);
      end
      prev_msb = exp_msb;
      nflush = 1'b0;
      if (act) begin
        if (b == cur.p - 1) begin
          act = 1'b0;
          nflush = !hs;
        end else begin
          b++;
        end
      end
      flush_now = nflush;
    end
  end

  task automatic send(input logic [7:0] base, input int prec, input int exp_p, input bit keep);
    bit accepted;
    @(posedge clk);
    #1;
    w_valid = 1'b1;
    for (int j = 0; j < VL; j++) w_in[j] = base + 8'(j * 37);
`ifdef SERIALIZER_VAR_PREC_EN
    w_prec = PW'(prec);
    drv_p = exp_p;
`else
    drv_p = (prec >= 0 && exp_p >= 0) ? DW : DW;
`endif
    accepted = 1'b0;
    for (int t = 0; t < 40 && !accepted; t++) begin
      @(negedge clk);
      accepted = w_ready;
    end
    chk("accept_timeout", 64'(accepted), 64'(1));
    if (!keep) begin
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      for (int j = 0; j < VL; j++) w_in[j] = 8'($urandom);
    end
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{w: 8'h81, prec: 8,  exp_p: 8};
    tbl[1] = '{w: 8'h0A, prec: 4,  exp_p: 4};
    tbl[2] = '{w: 8'h7F, prec: 0,  exp_p: 8};
    tbl[3] = '{w: 8'h35, prec: 12, exp_p: 8};
    tbl[4] = '{w: 8'hC3, prec: 3,  exp_p: 3};
    tbl[5] = '{w: 8'h01, prec: 1,  exp_p: 1};
    tbl[6] = '{w: 8'h80, prec: 8,  exp_p: 8};
    tbl[7] = '{w: 8'h5A, prec: 6,  exp_p: 6};
    for (int j = 0; j < VL; j++) w_in[j] = '0;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Idle: strobes must stay low while nothing is offered.
    repeat (20) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].w, tbl[i].prec, tbl[i].exp_p, 1'b0);
      repeat (12) @(posedge clk);
    end

    // Back-to-back vectors with w_valid held high.
    send(8'h81, 8, 8, 1'b1);
    send(8'h3C, 8, 8, 1'b0);
    repeat (14) @(posedge clk);
`ifdef SERIALIZER_VAR_PREC_EN
    send(8'h0A, 4, 4, 1'b1);
    send(8'h05, 3, 3, 1'b0);
    repeat (10) @(posedge clk);
`endif

    // Reset in the middle of a vector drops it entirely.
    send(8'h81, 8, 8, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    send(8'hA7, 8, 8, 1'b0);
    repeat (14) @(posedge clk);

    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    chk("rv_drained", 64'(rv_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
